// File: rtl/locker_btn_conditioner.sv
// Button input stage for the digit locker: synchronise, debounce and edge-detect four
// raw push-buttons, emitting clean levels and priority-resolved single-cycle press pulses.
module locker_btn_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] btn_raw,
   output logic [3:0] btn_level,
   output logic [3:0] btn_pulse,
   output logic       btn_any
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic [3:0]       sync1_q;
   logic [3:0]       sync2_q;
   logic [3:0]       stable_q;
   logic [3:0]       stable_d;
   logic [3:0]       pulse_q;
   logic [3:0]       pulse_d;
   logic [3:0]       rise;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];

   // A bit is accepted only after DEBOUNCE_CYCLES consecutive edges of disagreement;
   // any agreement in between drops the count back to zero.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CntOne;
            end
         end
      end
   end

   // Simultaneous presses: lowest index wins, the rest are dropped.
   always_comb begin
      rise    = stable_d & ~stable_q;
      pulse_d = '0;
      if (rise[0]) begin
         pulse_d = 4'b0001;
      end else if (rise[1]) begin
         pulse_d = 4'b0010;
      end else if (rise[2]) begin
         pulse_d = 4'b0100;
      end else if (rise[3]) begin
         pulse_d = 4'b1000;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         pulse_q  <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q  <= btn_raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         pulse_q  <= pulse_d;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign btn_level = stable_q;
   assign btn_pulse = pulse_q;
   assign btn_any   = |stable_q;

endmodule
